// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard detection (load-use, ID-stage branch, mult/div
// busy) producing hold/bubble, plus a mult/div busy sequencer and a
// saturating stall-cycle counter.
module hazard_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] insID,
    input  logic        memreadEX,
    input  logic        regwriteEX,
    input  logic [4:0]  wregEX,
    input  logic        memreadMEM,
    input  logic [4:0]  wregMEM,
    output logic        hold,
    output logic        bubble,
    output logic        mdbusy,
    output logic [31:0] stallcnt
);

    localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC + 1);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [CNT_W-1:0]   w_cnt_load;
    logic               r_mdbusy;
    logic [31:0]        r_stallcnt;
    logic [31:0]        w_stallcnt_nxt;

    logic [5:0]         w_op;
    logic [4:0]         w_rs;
    logic [4:0]         w_rt;
    logic [5:0]         w_funct;
    logic               w_rtype;
    logic               w_is_jr;
    logic               w_is_md;
    logic               w_is_mf;
    logic               w_is_br;
    logic               w_uses_rs;
    logic               w_uses_rt;
    logic               w_match_ex;
    logic               w_match_mem;
    logic               w_load_use;
    logic               w_br_haz;
    logic               w_md_haz;
    logic               w_hazard;

    // Instruction field decode for the ID stage.
    assign w_op      = insID[31:26];
    assign w_rs      = insID[25:21];
    assign w_rt      = insID[20:16];
    assign w_funct   = insID[5:0];
    assign w_rtype   = (w_op == OP_RTYPE);
    assign w_is_jr   = w_rtype && (w_funct == FN_JR);
    assign w_is_mf   = w_rtype && ((w_funct == FN_MFHI) || (w_funct == FN_MFLO));
    assign w_is_md   = w_rtype && ((w_funct == FN_MULT) || (w_funct == FN_MULTU) ||
                                   (w_funct == FN_DIV)  || (w_funct == FN_DIVU));
    assign w_is_br   = (w_op == OP_BEQ) || (w_op == OP_BNE) || w_is_jr;
    assign w_uses_rs = !((w_op == OP_J) || (w_op == OP_JAL) || (w_op == OP_LUI) ||
                         (insID == 32'h0));
    assign w_uses_rt = (w_rtype && !w_is_jr && !w_is_mf) ||
                       (w_op == OP_BEQ) || (w_op == OP_BNE) || (w_op == OP_SW);

    // Source/destination matching; register 0 never matches.
    assign w_match_ex  = (w_uses_rs && (w_rs != 5'd0) && (w_rs == wregEX)) ||
                         (w_uses_rt && (w_rt != 5'd0) && (w_rt == wregEX));
    assign w_match_mem = (w_uses_rs && (w_rs != 5'd0) && (w_rs == wregMEM)) ||
                         (w_uses_rt && (w_rt != 5'd0) && (w_rt == wregMEM));

    // Hazard terms; hold and bubble are deliberately combinational.
    assign w_load_use = memreadEX && w_match_ex;
    assign w_br_haz   = w_is_br && ((regwriteEX && w_match_ex) || (memreadMEM && w_match_mem));
    assign w_md_haz   = (w_is_md || w_is_mf) && r_mdbusy;
    assign w_hazard   = w_load_use || w_br_haz || w_md_haz;

    assign hold     = w_hazard;
    assign bubble   = w_hazard;
    assign mdbusy   = r_mdbusy;
    assign stallcnt = r_stallcnt;

    // div/divu have funct[1] set; mult/multu have it clear.
    assign w_cnt_load = w_funct[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

    // Next-state logic for the mult/div sequencer and stall counter.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_stallcnt_nxt = r_stallcnt;
        unique case (r_state)
            S_IDLE: begin
                if (w_is_md && !w_hazard && (w_cnt_load != '0)) begin
                    w_state_nxt = S_BUSY;
                    w_cnt_nxt   = w_cnt_load;
                end
            end
            S_BUSY: begin
                if (r_cnt <= CNT_W'(1)) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
        if (w_hazard && (r_stallcnt != 32'hFFFF_FFFF)) begin
            w_stallcnt_nxt = r_stallcnt + 32'd1;
        end
    end

    // State, counter and registered busy flag; reset aborts any operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_mdbusy   <= 1'b0;
            r_stallcnt <= 32'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_mdbusy   <= (w_state_nxt == S_BUSY);
            r_stallcnt <= w_stallcnt_nxt;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: vector table for the combinational hazard terms plus
// hand-written multi-cycle sequences, checked through an expectation queue.
module tb_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic [31:0] insID;
    logic        memreadEX;
    logic        regwriteEX;
    logic [4:0]  wregEX;
    logic        memreadMEM;
    logic [4:0]  wregMEM;
    logic        hold;
    logic        bubble;
    logic        mdbusy;
    logic [31:0] stallcnt;

    int n_pass  = 0;
    int n_total = 0;

    logic exp_q[$];

    typedef struct {
        logic [31:0] ins;
        logic        mrex;
        logic        rwex;
        logic [4:0]  wex;
        logic        mrmem;
        logic [4:0]  wmem;
        logic        exp;
    } vec_t;

    vec_t tbl[$];

    hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .insID      (insID),
        .memreadEX  (memreadEX),
        .regwriteEX (regwriteEX),
        .wregEX     (wregEX),
        .memreadMEM (memreadMEM),
        .wregMEM    (wregMEM),
        .hold       (hold),
        .bubble     (bubble),
        .mdbusy     (mdbusy),
        .stallcnt   (stallcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic vec_t mk(input logic [31:0] ins, input logic mrex, input logic rwex,
                                input logic [4:0] wex, input logic mrmem,
                                input logic [4:0] wmem, input logic exp);
        vec_t v;
        v.ins = ins; v.mrex = mrex; v.rwex = rwex; v.wex = wex;
        v.mrmem = mrmem; v.wmem = wmem; v.exp = exp;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic set_in(input logic [31:0] ins, input logic mrex, input logic rwex,
                          input logic [4:0] wex, input logic mrmem, input logic [4:0] wmem,
                          input logic exp);
        insID = ins; memreadEX = mrex; regwriteEX = rwex; wregEX = wex;
        memreadMEM = mrmem; wregMEM = wmem;
        exp_q.push_back(exp);
    endtask

    task automatic cmp_hold(input string nm);
        logic e;
        #1;
        if (exp_q.size() == 0) begin
            chk({nm, "_queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({nm, "_hold"}, {31'd0, hold}, {31'd0, e});
            chk({nm, "_bubble"}, {31'd0, bubble}, {31'd0, e});
        end
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        reset = 1'b1;
        insID = 32'h0; memreadEX = 1'b0; regwriteEX = 1'b0; wregEX = 5'd0;
        memreadMEM = 1'b0; wregMEM = 5'd0;
        #2;
        reset = 1'b0;
    endtask

    // Issue a mult/div, then keep mfhi/mflo in ID for the whole busy window.
    task automatic md_latency(input string nm, input logic [31:0] md, input logic [31:0] mf,
                              input int n);
        rst_pulse();
        @(negedge clk);
        set_in(md, 0, 0, 0, 0, 0, 1'b0);
        cmp_hold({nm, "_issue"});
        chk({nm, "_idle"}, {31'd0, mdbusy}, 32'd0);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            set_in(mf, 0, 0, 0, 0, 0, 1'b1);
            cmp_hold($sformatf("%s_held%0d", nm, k));
            chk($sformatf("%s_busy%0d", nm, k), {31'd0, mdbusy}, 32'd1);
        end
        @(negedge clk);
        set_in(mf, 0, 0, 0, 0, 0, 1'b0);
        cmp_hold({nm, "_release"});
        chk({nm, "_done"}, {31'd0, mdbusy}, 32'd0);
        chk({nm, "_stallcnt"}, stallcnt, n);
    endtask

    logic [31:0] add_3_2_4, beq_5_6, mult_1_2, div_1_2, mfhi_3, mflo_3;

    initial begin
        reset = 1'b1;
        insID = 32'h0; memreadEX = 1'b0; regwriteEX = 1'b0; wregEX = 5'd0;
        memreadMEM = 1'b0; wregMEM = 5'd0;

        add_3_2_4 = r_ins(5'd2, 5'd4, 5'd3, 6'h20);
        beq_5_6   = i_ins(6'h04, 5'd5, 5'd6, 16'h0004);
        mult_1_2  = r_ins(5'd1, 5'd2, 5'd0, 6'h18);
        div_1_2   = r_ins(5'd1, 5'd2, 5'd0, 6'h1A);
        mfhi_3    = r_ins(5'd0, 5'd0, 5'd3, 6'h10);
        mflo_3    = r_ins(5'd0, 5'd0, 5'd3, 6'h12);

        tbl.push_back(mk(add_3_2_4,                        1, 1, 5'd2, 0, 5'd0, 1'b1));
        tbl.push_back(mk(add_3_2_4,                        1, 1, 5'd4, 0, 5'd0, 1'b1));
        tbl.push_back(mk(add_3_2_4,                        1, 1, 5'd3, 0, 5'd0, 1'b0));
        tbl.push_back(mk(r_ins(5'd0, 5'd0, 5'd3, 6'h20),   1, 1, 5'd0, 0, 5'd0, 1'b0));
        tbl.push_back(mk(add_3_2_4,                        0, 1, 5'd2, 1, 5'd2, 1'b0));
        tbl.push_back(mk(i_ins(6'h0F, 5'd0, 5'd5, 16'h1), 1, 1, 5'd5, 0, 5'd0, 1'b0));
        tbl.push_back(mk(i_ins(6'h2B, 5'd6, 5'd5, 16'h0), 1, 1, 5'd5, 0, 5'd0, 1'b1));
        tbl.push_back(mk(i_ins(6'h23, 5'd5, 5'd7, 16'h0), 1, 1, 5'd7, 0, 5'd0, 1'b0));
        tbl.push_back(mk(i_ins(6'h23, 5'd5, 5'd7, 16'h0), 1, 1, 5'd5, 0, 5'd0, 1'b1));
        tbl.push_back(mk(i_ins(6'h08, 5'd2, 5'd5, 16'h1), 1, 1, 5'd5, 0, 5'd0, 1'b0));
        tbl.push_back(mk(beq_5_6,                          0, 1, 5'd6, 0, 5'd0, 1'b1));
        tbl.push_back(mk(beq_5_6,                          0, 0, 5'd6, 0, 5'd0, 1'b0));
        tbl.push_back(mk(beq_5_6,                          0, 0, 5'd0, 1, 5'd5, 1'b1));
        tbl.push_back(mk(i_ins(6'h05, 5'd5, 5'd6, 16'h0), 0, 0, 5'd0, 1, 5'd6, 1'b1));
        tbl.push_back(mk(r_ins(5'd5, 5'd0, 5'd0, 6'h08),   0, 1, 5'd5, 0, 5'd0, 1'b1));
        tbl.push_back(mk(r_ins(5'd5, 5'd0, 5'd0, 6'h08),   0, 0, 5'd0, 1, 5'd0, 1'b0));
        tbl.push_back(mk({6'h02, 26'h0A0_0000},           1, 1, 5'd5, 0, 5'd0, 1'b0));
        tbl.push_back(mk(mfhi_3,                           1, 1, 5'd3, 0, 5'd0, 1'b0));
        tbl.push_back(mk(32'h0,                            1, 1, 5'd0, 1, 5'd0, 1'b0));
        tbl.push_back(mk(mult_1_2,                         1, 1, 5'd2, 0, 5'd0, 1'b1));

        repeat (2) @(negedge clk);
        chk("rst_mdbusy", {31'd0, mdbusy}, 32'd0);
        chk("rst_stallcnt", stallcnt, 32'd0);

        // Table applied while reset is held: only load/branch terms can fire.
        for (int i = 0; i < tbl.size(); i++) begin
            set_in(tbl[i].ins, tbl[i].mrex, tbl[i].rwex, tbl[i].wex,
                   tbl[i].mrmem, tbl[i].wmem, tbl[i].exp);
            cmp_hold($sformatf("vec%0d", i));
            @(negedge clk);
        end
        chk("rst_tbl_stallcnt", stallcnt, 32'd0);
        chk("rst_tbl_mdbusy", {31'd0, mdbusy}, 32'd0);

        // Load-use costs one cycle.
        rst_pulse();
        @(negedge clk);
        set_in(add_3_2_4, 1, 1, 5'd2, 0, 5'd0, 1'b1);
        cmp_hold("lu_c1");
        @(negedge clk);
        set_in(add_3_2_4, 0, 0, 5'd0, 1, 5'd2, 1'b0);
        cmp_hold("lu_c2");
        chk("lu_stallcnt", stallcnt, 32'd1);

        // Branch after load: two consecutive hold cycles.
        rst_pulse();
        @(negedge clk);
        set_in(beq_5_6, 1, 1, 5'd5, 0, 5'd0, 1'b1);
        cmp_hold("brld_c1");
        @(negedge clk);
        set_in(beq_5_6, 0, 0, 5'd0, 1, 5'd5, 1'b1);
        cmp_hold("brld_c2");
        @(negedge clk);
        set_in(beq_5_6, 0, 0, 5'd0, 0, 5'd0, 1'b0);
        cmp_hold("brld_c3");
        chk("brld_stallcnt", stallcnt, 32'd2);

        md_latency("mult", mult_1_2, mfhi_3, 5);
        md_latency("div", div_1_2, mflo_3, 10);

        // Reset three cycles into a divide aborts it asynchronously.
        rst_pulse();
        @(negedge clk);
        set_in(div_1_2, 0, 0, 5'd0, 0, 5'd0, 1'b0);
        cmp_hold("rdiv_issue");
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            set_in(mflo_3, 0, 0, 5'd0, 0, 5'd0, 1'b1);
            cmp_hold($sformatf("rdiv_held%0d", k));
        end
        @(negedge clk);
        chk("rdiv_busy_pre", {31'd0, mdbusy}, 32'd1);
        chk("rdiv_stall_pre", stallcnt, 32'd2);
        #2 reset = 1'b1;
        #1;
        chk("rdiv_busy_async", {31'd0, mdbusy}, 32'd0);
        chk("rdiv_stall_async", stallcnt, 32'd0);
        set_in(mflo_3, 0, 0, 5'd0, 0, 5'd0, 1'b0);
        cmp_hold("rdiv_in_reset");
        @(negedge clk);
        reset = 1'b0;
        set_in(mflo_3, 0, 0, 5'd0, 0, 5'd0, 1'b0);
        cmp_hold("rdiv_after1");
        @(negedge clk);
        set_in(mflo_3, 0, 0, 5'd0, 0, 5'd0, 1'b0);
        cmp_hold("rdiv_after2");
        chk("rdiv_busy_after", {31'd0, mdbusy}, 32'd0);
        chk("rdiv_stall_after", stallcnt, 32'd0);

        // Back-to-back mult: second one held (incl. the BUSY->IDLE edge) then runs 5 cycles.
        rst_pulse();
        @(negedge clk);
        set_in(mult_1_2, 0, 0, 5'd0, 0, 5'd0, 1'b0);
        cmp_hold("b2b_issue");
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) set_in(mult_1_2, 1, 1, 5'd1, 0, 5'd0, 1'b1);
            else        set_in(mult_1_2, 0, 0, 5'd0, 0, 5'd0, 1'b1);
            cmp_hold($sformatf("b2b_held%0d", k));
            chk($sformatf("b2b_busy%0d", k), {31'd0, mdbusy}, 32'd1);
        end
        @(negedge clk);
        set_in(mult_1_2, 0, 0, 5'd0, 0, 5'd0, 1'b0);
        cmp_hold("b2b_accept");
        chk("b2b_gap", {31'd0, mdbusy}, 32'd0);
        chk("b2b_stallcnt", stallcnt, 32'd5);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            set_in(32'h0, 0, 0, 5'd0, 0, 5'd0, 1'b0);
            cmp_hold($sformatf("b2b_nop%0d", k));
            chk($sformatf("b2b_busy2_%0d", k), {31'd0, mdbusy}, 32'd1);
        end
        @(negedge clk);
        chk("b2b_done", {31'd0, mdbusy}, 32'd0);
        chk("b2b_queue_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $display("%0d/%0d checks passed", n_pass, n_total + 1);
        $fatal(1);
    end

endmodule
